z80fi_mem_log: RTL and testbench

- Retirement-side monitor that consumes the Z80 core's z80fi formal-interface retirement stream.
- Keeps saturating counters of retired instructions, memory reads and memory writes.
- Buffers each retired memory write (address and data) in a small FIFO, drained through a valid/ready port.
- Used by formal cover/assert harnesses and simulation benches as the single source of memory-activity statistics, replacing per-bench counters.

---
 rtl/z80fi_pkg.sv | 21 ++
 rtl/z80fi_sync_fifo.sv | 73 +++++++
 rtl/z80fi_mem_log.sv | 122 ++++++++++++
 tb/tb_z80fi_mem_log.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_pkg
// Description : Shared types and constants for the z80fi memory-activity
//               monitor: log-entry layout, entry width and default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package z80fi_pkg;

  // One logged memory write: address in the upper bits, data byte below.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } log_entry_t;

  localparam int c_entry_w       = 24;
  localparam int c_default_cnt_w = 32;
  localparam int c_default_depth = 8;

endpackage
`default_nettype wire

// File: rtl/z80fi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented combinationally from storage whenever the FIFO is
//               non-empty. Occupancy is kept in a dedicated level counter so
//               the pointers can simply wrap modulo DEPTH.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               push, wdata     - write request and entry
//               pop             - consume head entry (ignored when empty)
//               rdata           - head entry (valid while !empty)
//               full, empty     - occupancy flags
//               level           - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_sync_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_do_pop;
  logic w_do_push;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign rdata = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through level.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/z80fi_mem_log.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_mem_log
// Description : Retirement-side monitor on the z80fi formal interface. Keeps
//               saturating counts of retired instructions, memory reads and
//               memory writes, and logs every retired write {addr, data} into
//               a FIFO drained over a valid/ready port.
// Ports       : clk, reset                 - clock, sync active-high reset
//               z80fi_valid                - one instruction retires
//               z80fi_mem_rd / _mem_wr     - retiring access type
//               z80fi_mem_addr / _wdata    - retiring address / write byte
//               insn_count, memrd_count,
//               memwr_count                - saturating statistics
//               rd_and_wr_seen             - sticky, both reads and writes seen
//               log_valid/ready/addr/data  - write-log drain port
//               log_level                  - write-log occupancy
//               log_overflow               - sticky, a write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_mem_log
  import z80fi_pkg::*;
#(
  parameter int CNT_W = c_default_cnt_w,
  parameter int DEPTH = c_default_depth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     z80fi_valid,
  input  logic                     z80fi_mem_rd,
  input  logic                     z80fi_mem_wr,
  input  logic [15:0]              z80fi_mem_addr,
  input  logic [7:0]               z80fi_mem_wdata,
  output logic [CNT_W-1:0]         insn_count,
  output logic [CNT_W-1:0]         memrd_count,
  output logic [CNT_W-1:0]         memwr_count,
  output logic                     rd_and_wr_seen,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [15:0]              log_addr,
  output logic [7:0]               log_data,
  output logic [$clog2(DEPTH):0]   log_level,
  output logic                     log_overflow
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_insn_count;
  logic [CNT_W-1:0] r_memrd_count;
  logic [CNT_W-1:0] r_memwr_count;
  logic             r_rd_and_wr_seen;
  logic             r_log_overflow;

  logic             w_retire_rd;
  logic             w_retire_wr;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  log_entry_t       w_push_entry;
  log_entry_t       w_head;

  // Access qualifiers only mean something on a retiring cycle.
  assign w_retire_rd = z80fi_valid & z80fi_mem_rd;
  assign w_retire_wr = z80fi_valid & z80fi_mem_wr;

  assign w_pop  = log_valid & log_ready;
  // Full with no simultaneous pop: the write has nowhere to go.
  assign w_drop = w_retire_wr & w_full & ~w_pop;

  assign w_push_entry.addr = z80fi_mem_addr;
  assign w_push_entry.data = z80fi_mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_insn_count     <= '0;
      r_memrd_count    <= '0;
      r_memwr_count    <= '0;
      r_rd_and_wr_seen <= 1'b0;
      r_log_overflow   <= 1'b0;
    end else begin
      if (z80fi_valid && r_insn_count != c_cnt_max)
        r_insn_count <= r_insn_count + 1'b1;
      if (w_retire_rd && r_memrd_count != c_cnt_max)
        r_memrd_count <= r_memrd_count + 1'b1;
      // Dropped writes still count: the counter tracks retirements, not log
      // entries.
      if (w_retire_wr && r_memwr_count != c_cnt_max)
        r_memwr_count <= r_memwr_count + 1'b1;
      // Looks at the registered counts, so the flag trails them by a cycle.
      if (r_memrd_count != '0 && r_memwr_count != '0)
        r_rd_and_wr_seen <= 1'b1;
      if (w_drop)
        r_log_overflow <= 1'b1;
    end
  end

  z80fi_sync_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_retire_wr & ~w_drop),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (log_level)
  );

  assign insn_count     = r_insn_count;
  assign memrd_count    = r_memrd_count;
  assign memwr_count    = r_memwr_count;
  assign rd_and_wr_seen = r_rd_and_wr_seen;
  assign log_overflow   = r_log_overflow;
  assign log_valid      = ~w_empty;
  assign log_addr       = w_head.addr;
  assign log_data       = w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_z80fi_mem_log.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80fi_mem_log
// Description : Self-checking bench for z80fi_mem_log. Two instances share
//               the stimulus: default sizing and a 4-bit-counter variant that
//               exercises saturation. A queue-based reference model predicts
//               every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z80fi_mem_log;
  import z80fi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        z80fi_valid, z80fi_mem_rd, z80fi_mem_wr;
  logic [15:0] z80fi_mem_addr;
  logic [7:0]  z80fi_mem_wdata;
  logic        log_ready;

  logic [31:0] insn_count, memrd_count, memwr_count;
  logic        rd_and_wr_seen, log_valid, log_overflow;
  logic [15:0] log_addr;
  logic [7:0]  log_data;
  logic [3:0]  log_level;

  logic [3:0]  s_insn_count, s_memrd_count, s_memwr_count;
  logic        s_rd_and_wr_seen, s_log_valid, s_log_overflow;
  logic [15:0] s_log_addr;
  logic [7:0]  s_log_data;
  logic [3:0]  s_log_level;

  z80fi_mem_log #(.CNT_W(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .z80fi_valid(z80fi_valid), .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_wr(z80fi_mem_wr),
    .z80fi_mem_addr(z80fi_mem_addr), .z80fi_mem_wdata(z80fi_mem_wdata),
    .insn_count(insn_count), .memrd_count(memrd_count), .memwr_count(memwr_count),
    .rd_and_wr_seen(rd_and_wr_seen), .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_level(log_level),
    .log_overflow(log_overflow)
  );

  z80fi_mem_log #(.CNT_W(4), .DEPTH(8)) dut_sat (
    .clk(clk), .reset(reset),
    .z80fi_valid(z80fi_valid), .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_wr(z80fi_mem_wr),
    .z80fi_mem_addr(z80fi_mem_addr), .z80fi_mem_wdata(z80fi_mem_wdata),
    .insn_count(s_insn_count), .memrd_count(s_memrd_count), .memwr_count(s_memwr_count),
    .rd_and_wr_seen(s_rd_and_wr_seen), .log_valid(s_log_valid), .log_ready(log_ready),
    .log_addr(s_log_addr), .log_data(s_log_data), .log_level(s_log_level),
    .log_overflow(s_log_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: unbounded true counts, saturated per instance on compare.
  longint unsigned t_insn, t_rd, t_wr;
  bit              m_seen, m_ovf;
  logic [23:0]     m_q[$];

  function automatic longint unsigned sat(longint unsigned x, int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, push;
    if (reset) begin
      t_insn = 0; t_rd = 0; t_wr = 0;
      m_seen = 1'b0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      pop  = (m_q.size() != 0) && log_ready;
      push = z80fi_valid && z80fi_mem_wr;
      if (t_rd > 0 && t_wr > 0) m_seen = 1'b1;
      if (z80fi_valid)                 t_insn++;
      if (z80fi_valid && z80fi_mem_rd) t_rd++;
      if (z80fi_valid && z80fi_mem_wr) t_wr++;
      if (push && m_q.size() == 8 && !pop) begin
        m_ovf = 1'b1;
      end else begin
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({z80fi_mem_addr, z80fi_mem_wdata});
      end
    end
  endtask

  task automatic compare_all();
    check("insn_count",     64'(insn_count),  sat(t_insn, 32));
    check("memrd_count",    64'(memrd_count), sat(t_rd, 32));
    check("memwr_count",    64'(memwr_count), sat(t_wr, 32));
    check("rd_and_wr_seen", 64'(rd_and_wr_seen), 64'(m_seen));
    check("log_level",      64'(log_level),   64'(m_q.size()));
    check("log_valid",      64'(log_valid),   64'(m_q.size() != 0));
    check("log_overflow",   64'(log_overflow), 64'(m_ovf));
    if (m_q.size() != 0) begin
      check("log_addr", 64'(log_addr), 64'(m_q[0][23:8]));
      check("log_data", 64'(log_data), 64'(m_q[0][7:0]));
    end
    check("sat_insn_count",  64'(s_insn_count),  sat(t_insn, 4));
    check("sat_memrd_count", 64'(s_memrd_count), sat(t_rd, 4));
    check("sat_memwr_count", 64'(s_memwr_count), sat(t_wr, 4));
    check("sat_log_level",   64'(s_log_level),   64'(m_q.size()));
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, then
  // compare at the next falling edge.
  task automatic cyc(bit v, bit rd, bit wr, logic [15:0] a, logic [7:0] d, bit rdy);
    z80fi_valid = v; z80fi_mem_rd = rd; z80fi_mem_wr = wr;
    z80fi_mem_addr = a; z80fi_mem_wdata = d; log_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 16'h1111, 8'h22, 1'b0);
      check("rst_insn", 64'(insn_count), 64'd0);
      check("rst_memwr", 64'(memwr_count), 64'd0);
      check("rst_valid", 64'(log_valid), 64'd0);
      check("rst_ovf", 64'(log_overflow), 64'd0);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("post_rst_insn", 64'(insn_count), 64'd0);
    check("post_rst_valid", 64'(log_valid), 64'd0);
    check("post_rst_ovf", 64'(log_overflow), 64'd0);
  endtask

  initial begin
    int bias;
    reset = 1'b1;
    z80fi_valid = 1'b0; z80fi_mem_rd = 1'b0; z80fi_mem_wr = 1'b0;
    z80fi_mem_addr = '0; z80fi_mem_wdata = '0; log_ready = 1'b0;
    t_insn = 0; t_rd = 0; t_wr = 0; m_seen = 1'b0; m_ovf = 1'b0;
    @(negedge clk);

    // Reset with retirements pending, then three reads.
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 16'h1000 + 16'(i), 8'h00, 1'b0);
    check("rd3_memrd", 64'(memrd_count), 64'd3);
    check("rd3_memwr", 64'(memwr_count), 64'd0);
    check("rd3_insn", 64'(insn_count), 64'd3);
    check("rd3_level", 64'(log_level), 64'd0);
    check("rd3_seen", 64'(rd_and_wr_seen), 64'd0);

    // Read-modify-write.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 16'h8000, 8'h5A, 1'b0);
    check("rmw_memrd", 64'(memrd_count), 64'd1);
    check("rmw_memwr", 64'(memwr_count), 64'd1);
    check("rmw_addr", 64'(log_addr), 64'h8000);
    check("rmw_data", 64'(log_data), 64'h5A);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("rmw_seen", 64'(rd_and_wr_seen), 64'd1);

    // Fill past capacity, then drain in order.
    do_reset();
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 1'b0, 1'b1, 16'h2000 + 16'(i), 8'(i), 1'b0);
    check("fill_level", 64'(log_level), 64'd8);
    check("fill_ovf", 64'(log_overflow), 64'd1);
    check("fill_memwr", 64'(memwr_count), 64'd9);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", 64'(log_data), 64'(i));
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    end
    check("drain_empty", 64'(log_valid), 64'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 1'b1, 16'h2000 + 16'(i), 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h3000, 8'hAA, 1'b1);
    check("pp_level", 64'(log_level), 64'd8);
    check("pp_ovf", 64'(log_overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("pp_last", 64'(log_data), 64'hAA);
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b1);
    end

    // Saturation of the 4-bit instance.
    do_reset();
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("sat_insn15", 64'(s_insn_count), 64'd15);
    check("wide_insn20", 64'(insn_count), 64'd20);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
    check("sat_insn_hold", 64'(s_insn_count), 64'd15);

    // Randomised traffic with varying drain pressure and occasional reset.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = (i / 200) % 3 == 0 ? 10 : ((i / 200) % 3 == 1 ? 50 : 90);
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
          16'($urandom), 8'($urandom), $urandom_range(0, 99) < bias);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
